// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: owner encoding and
// the default burst cap.
package mem_arb_pkg;

   // Who currently holds the memory (the tenure being counted by cnt).
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_P0   = 2'd1,
      OWN_P1   = 2'd2
   } owner_t;

   // Default maximum consecutive grants to one port under contention.
   localparam int MAXBURST_DEF = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester handshakes and memory-side lines for mem_arbiter.
// slave  : the arbiter's view (takes requests, drives grants and memory).
// master : the surrounding top level's view (requesters plus memory).
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int S = 32,
   parameter int L = 256
) ();
   localparam int AW = $clog2(L);

   logic          req0,    req1;
   logic          we0,     we1;
   logic [AW-1:0] addr0,   addr1;
   logic [S-1:0]  wdata0,  wdata1;
   logic          gnt0,    gnt1;
   logic          rvalid0, rvalid1;
   logic [S-1:0]  rdata0,  rdata1;

   logic [AW-1:0] mem_a;
   logic [S-1:0]  mem_din;
   logic [S-1:0]  mem_dout;
   logic          mem_mwrite;
   logic          mem_mread;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
             mem_a, mem_din, mem_mwrite, mem_mread
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
             mem_a, mem_din, mem_mwrite, mem_mread
   );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with a burst cap sharing one single-port synchronous
// memory between two requesters. Grants are combinational (the access
// happens in the cycle it is granted); read data returns one cycle later.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int S        = 32,
   parameter int L        = 256,
   parameter int MAXBURST = MAXBURST_DEF
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   localparam int AW = $clog2(L);
   localparam int CW = $clog2(MAXBURST + 1);
   localparam logic [CW-1:0] CAP = CW'(MAXBURST);

   owner_t        owner;
   logic          last;       // 1 = port 1 was granted most recently
   logic [CW-1:0] cnt;

   logic          g0, g1;
   logic          rvalid0_q, rvalid1_q;
   logic [S-1:0]  rdata0_q,  rdata1_q;

   // Grant decision: stay with the owner until it idles or hits the cap
   // while the other port waits; ties from idle go to the port not served last.
   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (!rst) begin
         unique case (owner)
            OWN_P0: begin
               if (bus.req0 && (cnt < CAP || !bus.req1)) g0 = 1'b1;
               else                                      g1 = bus.req1;
            end
            OWN_P1: begin
               if (bus.req1 && (cnt < CAP || !bus.req0)) g1 = 1'b1;
               else                                      g0 = bus.req0;
            end
            default: begin
               if (bus.req0 && bus.req1) begin
                  g0 = last;
                  g1 = !last;
               end else begin
                  g0 = bus.req0;
                  g1 = bus.req1;
               end
            end
         endcase
      end
   end

   // Ownership, round-robin history and saturating tenure counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner <= OWN_NONE;
         last  <= 1'b1;
         cnt   <= '0;
      end else if (g0 || g1) begin
         owner <= g0 ? OWN_P0 : OWN_P1;
         last  <= g1;
         if ((g0 && owner == OWN_P0) || (g1 && owner == OWN_P1))
            cnt <= (cnt == CAP) ? CAP : cnt + CW'(1);
         else
            cnt <= CW'(1);
      end else begin
         owner <= OWN_NONE;
         cnt   <= '0;
      end
   end

   // Capture memory read data for the port whose read was granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         rvalid0_q <= g0 && !bus.we0;
         rvalid1_q <= g1 && !bus.we1;
         if (g0 && !bus.we0) rdata0_q <= bus.mem_dout;
         if (g1 && !bus.we1) rdata1_q <= bus.mem_dout;
      end
   end

   // Memory drive from the granted port; everything low when idle or in reset.
   always_comb begin
      bus.mem_a      = '0;
      bus.mem_din    = '0;
      bus.mem_mwrite = 1'b0;
      bus.mem_mread  = 1'b0;
      if (g0) begin
         bus.mem_a      = bus.addr0;
         bus.mem_din    = bus.wdata0;
         bus.mem_mwrite = bus.we0;
         bus.mem_mread  = !bus.we0;
      end else if (g1) begin
         bus.mem_a      = bus.addr1;
         bus.mem_din    = bus.wdata1;
         bus.mem_mwrite = bus.we1;
         bus.mem_mread  = !bus.we1;
      end
   end

   // Reset blanks the returned read outputs in the cycle it is asserted too.
   assign bus.gnt0    = g0;
   assign bus.gnt1    = g1;
   assign bus.rvalid0 = rvalid0_q && !rst;
   assign bus.rvalid1 = rvalid1_q && !rst;
   assign bus.rdata0  = rst ? '0 : rdata0_q;
   assign bus.rdata1  = rst ? '0 : rdata1_q;

   logic [AW-1:0] unused_aw;
   assign unused_aw = '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a port-indexed reference
// model with its own shadow memory.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int S    = 32;
   localparam int L    = 256;
   localparam int MAXB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   mem_arbiter_if #(.S(S), .L(L)) bus ();

   mem_arbiter #(.S(S), .L(L), .MAXBURST(MAXB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(int i);
      return 32'(i + 1) * 32'h9E3779B9;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory beside the arbiter: combinational read, write on the edge.
   logic [31:0] mem [L];
   bit          mem_init = 1'b0;
   assign bus.mem_dout = mem[bus.mem_a];
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < L; i++) mem[i] <= init_word(i);
         mem_init <= 1'b1;
      end else if (bus.mem_mwrite) begin
         mem[bus.mem_a] <= bus.mem_din;
      end
   end

   // Reference model state: owner is -1 (none), 0 or 1.
   int          m_owner = -1;
   int          m_last  = 1;
   int          m_cnt   = 0;
   bit          m_rv [2];
   logic [31:0] m_rd [2];
   bit          m_gnt [2];
   logic [31:0] ref_mem [L];
   bit          ref_init = 1'b0;

   function automatic int pick(bit r0, bit r1, int owner, int last, int cnt);
      bit r [2];
      r[0] = r0;
      r[1] = r1;
      if (owner >= 0) begin
         if (r[owner] && (cnt < MAXB || !r[1-owner])) return owner;
         if (r[1-owner]) return 1 - owner;
         return -1;
      end
      if (r[0] && r[1]) return 1 - last;
      if (r[0]) return 0;
      if (r[1]) return 1;
      return -1;
   endfunction

   // Per-cycle compare of every DUT output against the model, then advance it.
   always @(negedge clk) begin
      bit          rq [2];
      bit          we [2];
      logic [7:0]  ad [2];
      logic [31:0] wd [2];
      int          p;
      if (!ref_init) begin
         for (int i = 0; i < L; i++) ref_mem[i] = init_word(i);
         m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
         ref_init = 1'b1;
      end
      rq[0] = bus.req0;  rq[1] = bus.req1;
      we[0] = bus.we0;   we[1] = bus.we1;
      ad[0] = bus.addr0; ad[1] = bus.addr1;
      wd[0] = bus.wdata0; wd[1] = bus.wdata1;
      p = rst ? -1 : pick(rq[0], rq[1], m_owner, m_last, m_cnt);
      m_gnt[0] = (p == 0);
      m_gnt[1] = (p == 1);

      chk("gnt0", bus.gnt0, m_gnt[0]);
      chk("gnt1", bus.gnt1, m_gnt[1]);
      chk("mem_a",      bus.mem_a,      (p >= 0) ? ad[p] : 8'd0);
      chk("mem_din",    bus.mem_din,    (p >= 0) ? wd[p] : 32'd0);
      chk("mem_mwrite", bus.mem_mwrite, (p >= 0) ? we[p] : 1'b0);
      chk("mem_mread",  bus.mem_mread,  (p >= 0) ? !we[p] : 1'b0);
      chk("rvalid0", bus.rvalid0, m_rv[0] && !rst);
      chk("rvalid1", bus.rvalid1, m_rv[1] && !rst);
      chk("rdata0",  bus.rdata0,  rst ? 32'd0 : m_rd[0]);
      chk("rdata1",  bus.rdata1,  rst ? 32'd0 : m_rd[1]);

      if (rst) begin
         m_owner = -1; m_last = 1; m_cnt = 0;
         m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
      end else begin
         for (int x = 0; x < 2; x++) begin
            m_rv[x] = (p == x) && !we[x];
            if (m_rv[x]) m_rd[x] = ref_mem[ad[x]];
         end
         if (p >= 0) begin
            if (we[p]) ref_mem[ad[p]] = wd[p];
            m_cnt   = (p == m_owner) ? ((m_cnt + 1 > MAXB) ? MAXB : m_cnt + 1) : 1;
            m_owner = p;
            m_last  = p;
         end else begin
            m_owner = -1;
            m_cnt   = 0;
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   bit fair_pat [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

   initial begin
      bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
      rst = 1'b1;

      // Reset values.
      @(negedge clk);
      chk("rst_gnt0",    bus.gnt0,    1'b0);
      chk("rst_rvalid0", bus.rvalid0, 1'b0);
      chk("rst_rdata1",  bus.rdata1,  32'd0);
      chk("rst_mwrite",  bus.mem_mwrite, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Tie after reset, then continuous contention in runs of MAXB.
      bus.req0 = 1; bus.addr0 = 8'h10;
      bus.req1 = 1; bus.addr1 = 8'h20;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("fair_gnt1", bus.gnt1, fair_pat[i]);
         chk("fair_one",  32'(bus.gnt0) + 32'(bus.gnt1), 32'd1);
         if (i > 0) chk("fair_rv", bus.rvalid0 || bus.rvalid1, 1'b1);
         next_cycle();
      end
      bus.req0 = 0; bus.req1 = 0;
      next_cycle();

      // Sole requester saturates, then the cap hands over to port 0.
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h40;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("sole_gnt1", bus.gnt1, 1'b1);
         next_cycle();
      end
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h41;
      @(negedge clk);
      chk("cap_switch", bus.gnt0, 1'b1);
      next_cycle();
      bus.req0 = 0; bus.req1 = 0;
      next_cycle();

      // Write then read of the same address from the other port.
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h05; bus.wdata0 = 32'hDEADBEEF;
      @(negedge clk);
      chk("wr_gnt0", bus.gnt0, 1'b1);
      next_cycle();
      bus.req0 = 0; bus.we0 = 0;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h05;
      @(negedge clk);
      chk("rd_gnt1", bus.gnt1, 1'b1);
      next_cycle();
      bus.req1 = 0;
      @(negedge clk);
      chk("rd_rvalid1", bus.rvalid1, 1'b1);
      chk("rd_rdata1",  bus.rdata1,  32'hDEADBEEF);
      next_cycle();

      // Reset in the middle of a port-0 write burst.
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h30; bus.wdata0 = 32'h1;
      next_cycle();
      bus.addr0 = 8'h31; bus.wdata0 = 32'h2;
      next_cycle();
      bus.addr0 = 8'h07; bus.wdata0 = 32'h12345678;
      rst = 1'b1;
      @(negedge clk);
      chk("rstburst_gnt0",   bus.gnt0,       1'b0);
      chk("rstburst_mwrite", bus.mem_mwrite, 1'b0);
      next_cycle();
      rst = 1'b0;
      bus.we0 = 0; bus.addr0 = 8'h07;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h20;
      @(negedge clk);
      chk("rstburst_tie",  bus.gnt0, 1'b1);
      chk("rstburst_mem7", mem[7],   init_word(7));
      next_cycle();
      bus.req0 = 0;
      @(negedge clk);
      chk("rstburst_rv0", bus.rvalid0, 1'b1);
      chk("rstburst_rd0", bus.rdata0,  init_word(7));
      chk("rstburst_g1",  bus.gnt1,    1'b1);
      next_cycle();

      // Idle gap after a port-1 grant: the next tie goes to port 0.
      bus.req1 = 0;
      next_cycle();
      bus.req0 = 1; bus.addr0 = 8'h11;
      bus.req1 = 1; bus.addr1 = 8'h12;
      @(negedge clk);
      chk("idle_gap_gnt0", bus.gnt0, 1'b1);
      next_cycle();

      // Randomized traffic; a request holds its attributes until granted.
      for (int c = 0; c < 3000; c++) begin
         if (!(bus.req0 && !m_gnt[0])) begin
            bus.req0   = ($urandom_range(0, 3) != 0);
            bus.we0    = $urandom_range(0, 1);
            bus.addr0  = 8'($urandom_range(0, 15));
            bus.wdata0 = $urandom;
         end
         if (!(bus.req1 && !m_gnt[1])) begin
            bus.req1   = ($urandom_range(0, 3) != 0);
            bus.we1    = $urandom_range(0, 1);
            bus.addr1  = 8'($urandom_range(0, 15));
            bus.wdata1 = $urandom;
         end
         rst = ($urandom_range(0, 99) == 0);
         next_cycle();
      end
      rst = 1'b0;
      bus.req0 = 0; bus.req1 = 0;
      next_cycle();
      next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
